// File: rtl/bcd_pkg.sv
// Shared constants for the BCD display path: FSM encodings, digit count,
// the largest representable value and the saturation pattern.
package bcd_pkg;

    localparam logic S_IDLE  = 1'b0;
    localparam logic S_SHIFT = 1'b1;

    typedef enum logic {
        ST_IDLE  = S_IDLE,
        ST_SHIFT = S_SHIFT
    } state_t;

    localparam int DIGITS_DEF = 4;

    // Largest value that fits in the given number of decimal digits.
    function automatic int max_for(input int digits);
        int m;
        m = 1;
        for (int i = 0; i < digits; i++) begin
            m = m * 10;
        end
        return m - 1;
    endfunction

    // All-nines word, low 4*digits bits meaningful.
    function automatic logic [63:0] sat_word(input int digits);
        logic [63:0] w;
        w = 64'd0;
        for (int i = 0; i < digits; i++) begin
            w[4*i +: 4] = 4'h9;
        end
        return w;
    endfunction

    localparam int                       MAX_DEF     = max_for(DIGITS_DEF);
    localparam logic [4*DIGITS_DEF-1:0]  SAT_PATTERN = {DIGITS_DEF{4'h9}};

endpackage

// File: rtl/bcd_add3.sv
// Per-digit double-dabble correction: adds 3 to a BCD nibble of 5 or more.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Nibble correction, no carry out.
    always_comb begin
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-and-add-3 binary to packed-BCD converter, one bit per cycle,
// with a held output word and saturation to all nines on overflow.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter  int BIN_W  = 14,
    parameter  int DIGITS = DIGITS_DEF,
    localparam int MAX    = max_for(DIGITS)
) (
    input  logic                  sysclk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf
);

    localparam int                W        = 4 * DIGITS;
    localparam int                CNT_W    = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(BIN_W);
    localparam logic [31:0]       MAX_W    = MAX;
    localparam logic [63:0]       SAT_ALL  = sat_word(DIGITS);
    localparam logic [W-1:0]      SAT      = SAT_ALL[W-1:0];

    state_t                 state_r, state_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s;
    logic [W-1:0]           scr_r, scr_s;
    logic [BIN_W-1:0]       sh_r, sh_s;
    logic                   ovfp_r, ovfp_s;
    logic [W-1:0]           bcd_r, bcd_s;
    logic                   ovf_r, ovf_s;
    logic                   done_r, done_s;
    logic                   busy_r;
    logic [W-1:0]           corr_s;
    logic [W+BIN_W-1:0]     cat_s;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (scr_r[4*g +: 4]),
            .dout (corr_s[4*g +: 4])
        );
    end

    // Corrected scratch and remaining binary bits shift left together;
    // the scratch MSB falls off and only matters when saturating.
    assign cat_s = {corr_s, sh_r} << 1;

    // Next-state and datapath update.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        scr_s   = scr_r;
        sh_s    = sh_r;
        ovfp_s  = ovfp_r;
        bcd_s   = bcd_r;
        ovf_s   = ovf_r;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_SHIFT;
                    sh_s    = bin;
                    scr_s   = {W{1'b0}};
                    cnt_s   = CNT_LOAD;
                    ovfp_s  = (32'(bin) > MAX_W);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                scr_s = cat_s[W+BIN_W-1:BIN_W];
                sh_s  = cat_s[BIN_W-1:0];
                cnt_s = cnt_r - CNT_W'(1);
                if (cnt_r == CNT_W'(1)) begin
                    state_s = ST_IDLE;
                    bcd_s   = ovfp_r ? SAT : cat_s[W+BIN_W-1:BIN_W];
                    ovf_s   = ovfp_r;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            scr_r   <= {W{1'b0}};
            sh_r    <= {BIN_W{1'b0}};
            ovfp_r  <= 1'b0;
            bcd_r   <= {W{1'b0}};
            ovf_r   <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            scr_r   <= scr_s;
            sh_r    <= sh_s;
            ovfp_r  <= ovfp_s;
            bcd_r   <= bcd_s;
            ovf_r   <= ovf_s;
            done_r  <= done_s;
            busy_r  <= (state_s == ST_SHIFT);
        end
    end

    assign bcd  = bcd_r;
    assign busy = busy_r;
    assign done = done_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq at default parameters.
module tb_bin2bcd_seq;

    logic        sysclk = 1'b0;
    logic        reset;
    logic        start;
    logic [13:0] bin;
    logic [15:0] bcd;
    logic        busy;
    logic        done;
    logic        ovf;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] last_bcd;

    always #5 sysclk = ~sysclk;

    bin2bcd_seq dut (
        .sysclk (sysclk),
        .reset  (reset),
        .start  (start),
        .bin    (bin),
        .bcd    (bcd),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf)
    );

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic pulse_start(input logic [13:0] v);
        start = 1'b1;
        bin   = v;
        tick();
        start = 1'b0;
    endtask

    // Waits (bounded) for done; reports cycles waited and whether busy stayed
    // high and bcd stayed at hold_val in every cycle before done.
    task automatic wait_done(input logic [15:0] hold_val, output int lat, output bit stable);
        lat    = 0;
        stable = 1'b1;
        while (done !== 1'b1 && lat < 30) begin
            if (busy !== 1'b1 || bcd !== hold_val) stable = 1'b0;
            tick();
            lat++;
        end
    endtask

    function automatic logic [15:0] dec_split(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        bin   = 14'd0;
        tick();
        tick();
        checks++;
        if (bcd !== 16'h0000 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset: bcd=%h busy=%b done=%b ovf=%b, want 0000 0 0 0", bcd, busy, done, ovf);
        end
        reset = 1'b0;
        tick();
        last_bcd = 16'h0000;
    endtask

    task automatic test_value(input logic [13:0] v, input logic [15:0] exp_bcd,
                              input logic exp_ovf, input string name);
        int lat;
        bit stable;
        pulse_start(v);
        wait_done(last_bcd, lat, stable);
        checks++;
        if (lat !== 14) begin
            failures++;
            $display("FAIL %s latency: got %0d cycles, want 14", name, lat);
        end
        checks++;
        if (!stable) begin
            failures++;
            $display("FAIL %s hold: busy/bcd changed before done, want busy=1 bcd=%h", name, last_bcd);
        end
        checks++;
        if (bcd !== exp_bcd || ovf !== exp_ovf) begin
            failures++;
            $display("FAIL %s result: bcd=%h ovf=%b, want bcd=%h ovf=%b", name, bcd, ovf, exp_bcd, exp_ovf);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_end: busy=%b, want 0", name, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || bcd !== exp_bcd) begin
            failures++;
            $display("FAIL %s done_pulse: done=%b bcd=%h, want 0 %h", name, done, bcd, exp_bcd);
        end
        last_bcd = exp_bcd;
    endtask

    task automatic test_busy_ignore();
        int lat;
        bit stable;
        pulse_start(14'd5);
        repeat (5) tick();
        start = 1'b1;
        bin   = 14'd77;
        tick();
        start = 1'b0;
        wait_done(last_bcd, lat, stable);
        checks++;
        if (lat + 6 !== 14 || bcd !== 16'h0005 || !stable) begin
            failures++;
            $display("FAIL busy_ignore: lat=%0d bcd=%h stable=%b, want 14 0005 1", lat + 6, bcd, stable);
        end
        last_bcd = 16'h0005;
    endtask

    task automatic test_back_to_back();
        int lat;
        bit stable;
        start = 1'b1;
        bin   = 14'd77;
        tick();
        start = 1'b0;
        wait_done(last_bcd, lat, stable);
        checks++;
        if (lat !== 14 || bcd !== 16'h0077 || ovf !== 1'b0 || !stable) begin
            failures++;
            $display("FAIL back_to_back: lat=%0d bcd=%h ovf=%b, want 14 0077 0", lat, bcd, ovf);
        end
        tick();
        last_bcd = 16'h0077;
    endtask

    task automatic test_reset_abort();
        bit seen;
        pulse_start(14'd4321);
        repeat (6) tick();
        reset = 1'b1;
        start = 1'b1;
        bin   = 14'd9;
        tick();
        reset = 1'b0;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== 16'h0000 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort: busy=%b done=%b bcd=%h ovf=%b, want 0 0 0000 0", busy, done, bcd, ovf);
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL reset_abort_quiet: done/busy seen after abort, want none");
        end
        last_bcd = 16'h0000;
        test_value(14'd58, 16'h0058, 1'b0, "after_abort");
    endtask

    task automatic test_sweep();
        int lat;
        bit stable;
        logic [15:0] exp_v;
        pulse_start(14'd0);
        for (int v = 0; v <= 9999; v += 3) begin
            wait_done(16'h0000, lat, stable);
            exp_v = dec_split(v);
            checks++;
            if (lat > 14 || bcd !== exp_v || ovf !== 1'b0) begin
                failures++;
                $display("FAIL sweep %0d: bcd=%h ovf=%b lat=%0d, want %h 0 <=14", v, bcd, ovf, lat, exp_v);
            end
            if (v + 3 <= 9999) begin
                start = 1'b1;
                bin   = 14'(v + 3);
                tick();
                start = 1'b0;
            end
        end
        tick();
        last_bcd = 16'h9999;
    endtask

    initial begin
        test_reset();
        test_value(14'd0,     16'h0000, 1'b0, "zero");
        test_value(14'd1234,  16'h1234, 1'b0, "v1234");
        test_value(14'd9999,  16'h9999, 1'b0, "v9999");
        test_value(14'd10000, 16'h9999, 1'b1, "v10000");
        test_value(14'd16383, 16'h9999, 1'b1, "v16383");
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
